// File: rtl/dsp_pkg.sv
// Shared constants and types for the delayed-LMS stimulus/reference source.
package dsp_pkg;

    // Default datapath widths: samples and coefficients, and their full product.
    localparam int SAMPLE_W = 8;
    localparam int PROD_W   = 16;

    // Coefficients are Q1.7, so a product is rescaled by this many bits.
    localparam int Q_SHIFT = 7;

    // Output saturation range for a W1 = 8 sample.
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    // Feedback taps 16, 14, 13, 11 of the 16-bit Fibonacci LFSR, expressed as bit positions 15, 13, 12, 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR: the current value is the output, and it shifts on enabled edges.
module lfsr16
    import dsp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic fb;

    assign fb = ^(value & LFSR_TAPS);

    // Load the seed on reset; otherwise shift left and insert the feedback bit when enabled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register reads pre-edge values.
        if (reset) begin
            value <= seed;
        end else if (enable) begin
            value <= {value[14:0], fb};
        end
    end

endmodule

// File: rtl/dlms_plant_gen.sv
// Stimulus source for the delayed-LMS filter. It produces x(n) from an LFSR or an external port.
// It runs x(n) through a loadable L-tap plant FIR to form d(n), and outputs each x/d pair on the same cycle.
module dlms_plant_gen
    import dsp_pkg::*;
#(
    parameter int          W1   = SAMPLE_W,
    parameter int          W2   = PROD_W,
    parameter int          L    = 4,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [W1-1:0] load_data,
    output logic          load_ready,
    input  logic          start,
    input  logic          stop,
    input  logic          ext_sel,
    input  logic [W1-1:0] x_ext,
    output logic [W1-1:0] x_out,
    output logic [W1-1:0] d_out,
    output logic          valid_out,
    output logic          busy
);

    localparam int SW = W2 + 3;
    localparam int IW = $clog2(L);
    localparam logic [IW-1:0]        LAST_IDX = IW'(L - 1);
    localparam logic signed [SW-1:0] SUM_HI   = SW'(SAT_MAX);
    localparam logic signed [SW-1:0] SUM_LO   = SW'(SAT_MIN);

    state_t        state, state_d;
    logic [1:0]    flush_cnt;
    logic [IW-1:0] load_idx;

    logic take_sample;
    logic load_accept;
    logic clear_hist;

    logic [15:0]           lfsr;
    logic                  unused_lfsr_hi;
    logic signed [W1-1:0]  xs;
    logic signed [W1-1:0]  coef [L];
    logic signed [W1-1:0]  hist [L-1];
    logic signed [W1-1:0]  tap  [L];

    logic signed [W2-1:0]  prod [L];
    logic signed [SW-1:0]  sum_d, sum_q, scaled;
    logic signed [W1-1:0]  d_sat;
    logic [W1-1:0]         x_s1, x_s2;
    logic                  v1, v2;

    // ------------------------------------------------------------------
    // Sample source
    // ------------------------------------------------------------------
    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (take_sample && !ext_sel),
        .seed   (SEED),
        .value  (lfsr)
    );

    // Only the low W1 bits become samples; the upper bits exist only for the sequence.
    assign unused_lfsr_hi = ^lfsr[15:W1];

    assign xs = ext_sel ? x_ext : lfsr[W1-1:0];

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------

    // State register and the three-cycle drain counter that runs only while in FLUSH.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_d;
            flush_cnt <= (state == FLUSH && state_d == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
        end
    end

    // Next-state and control decode. A load beats start in IDLE, and RUN still samples on its stop cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state;
        load_ready  = 1'b0;
        busy        = 1'b1;
        take_sample = 1'b0;
        load_accept = 1'b0;
        clear_hist  = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                busy       = 1'b0;
                if (load_valid) begin
                    load_accept = 1'b1;
                    state_d     = LOAD;
                end else if (start) begin
                    clear_hist = 1'b1;
                    state_d    = RUN;
                end
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    load_accept = 1'b1;
                    if (load_idx == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end
            RUN: begin
                take_sample = 1'b1;
                if (stop) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_cnt == 2'd2) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Coefficient store and tap history
    // ------------------------------------------------------------------

    // Write accepted coefficient words in order c0..c(L-1). The index wraps to 0 when a load completes.
    always_ff @(posedge clk) begin
        // NOTE: this small register array is reset explicitly, because a restart without a load must see all-zero coefficients.
        if (reset) begin
            for (int k = 0; k < L; k++) begin
                coef[k] <= '0;
            end
            load_idx <= '0;
        end else if (load_accept) begin
            coef[load_idx] <= load_data;
            load_idx       <= (load_idx == LAST_IDX) ? '0 : load_idx + 1'b1;
        end
    end

    // Shift each new sample into the delay line. A fresh run starts from an all-zero history.
    always_ff @(posedge clk) begin
        if (reset || clear_hist) begin
            for (int k = 0; k < L - 1; k++) begin
                hist[k] <= '0;
            end
        end else if (take_sample) begin
            hist[0] <= xs;
            for (int k = 1; k < L - 1; k++) begin
                hist[k] <= hist[k-1];
            end
        end
    end

    // Tap 0 is the sample arriving this cycle, so the product stage sees x(n) without an extra delay.
    always_comb begin
        tap[0] = xs;
        for (int k = 1; k < L; k++) begin
            tap[k] = hist[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Plant FIR pipeline: products -> sum -> scale/saturate
    // ------------------------------------------------------------------

    // S1: register the signed products and the sample they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1   <= 1'b0;
            x_s1 <= '0;
            for (int k = 0; k < L; k++) begin
                prod[k] <= '0;
            end
        end else begin
            v1 <= take_sample;
            if (take_sample) begin
                x_s1 <= xs;
                for (int k = 0; k < L; k++) begin
                    prod[k] <= W2'(coef[k]) * W2'(tap[k]);
                end
            end
        end
    end

    // Sign-extend each product into the wider accumulator, so L products cannot overflow.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < L; k++) begin
            sum_d = sum_d + SW'(prod[k]);
        end
    end

    // S2: register the sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            v2    <= 1'b0;
            sum_q <= '0;
            x_s2  <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                sum_q <= sum_d;
                x_s2  <= x_s1;
            end
        end
    end

    // Drop the Q1.7 fraction with a flooring arithmetic shift, then clip to the sample range.
    always_comb begin
        scaled = sum_q >>> Q_SHIFT;
        if (scaled > SUM_HI) begin
            d_sat = W1'(SAT_MAX);
        end else if (scaled < SUM_LO) begin
            d_sat = W1'(SAT_MIN);
        end else begin
            d_sat = scaled[W1-1:0];
        end
    end

    // S3: update the outputs only with valid pairs, so x_out and d_out hold their last values otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_out <= 1'b0;
            x_out     <= '0;
            d_out     <= '0;
        end else begin
            valid_out <= v2;
            if (v2) begin
                x_out <= x_s2;
                d_out <= d_sat;
            end
        end
    end

endmodule
